// File: rtl/diff_freq_serial_out_if.sv
// Byte-in / serial-out bundle for the packet-programmed pattern generator.
// The slave side is the generator; the master side is the UART rx path.
interface diff_freq_serial_out_if;
    logic [7:0] i_data;
    logic       i_rx_done_tick;
    logic       o_serial_out;
    logic       o_bit_tick;
    logic       o_done_tick;

    modport master (
        output i_data,
        output i_rx_done_tick,
        input  o_serial_out,
        input  o_bit_tick,
        input  o_done_tick
    );

    modport slave (
        input  i_data,
        input  i_rx_done_tick,
        output o_serial_out,
        output o_bit_tick,
        output o_done_tick
    );
endinterface

// File: rtl/diff_freq_serial_out.sv
// Assembles data/speed/command packets from UART bytes and shifts the data
// word out LSB-first, each bit lasting a LOW or HIGH speed period.
module diff_freq_serial_out #(
    parameter int DATA_BIT    = 32,
    parameter int PACK_NUM    = 9,
    parameter int LOW_PERIOD  = 20,
    parameter int HIGH_PERIOD = 10,
    parameter int DIV_BIT     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    diff_freq_serial_out_if.slave  bus
);

    localparam int NB    = DATA_BIT / 8;
    localparam int CNT_W = $clog2(PACK_NUM);
    localparam int IDX_W = $clog2(DATA_BIT);

    localparam logic [CNT_W-1:0] CMD_POS  = CNT_W'(PACK_NUM - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BIT - 1);
    localparam logic [DIV_BIT-1:0] LOW_LAST  = DIV_BIT'(LOW_PERIOD - 1);
    localparam logic [DIV_BIT-1:0] HIGH_LAST = DIV_BIT'(HIGH_PERIOD - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]    byte_cnt;
    logic [DATA_BIT-1:0] data_buf;
    logic [DATA_BIT-1:0] speed_buf;
    logic [DATA_BIT-1:0] shadow_data;
    logic [DATA_BIT-1:0] shadow_speed;
    logic                repeat_mode;

    logic [IDX_W-1:0]   bit_idx;
    logic [IDX_W-1:0]   bit_idx_nxt;
    logic [DIV_BIT-1:0] div_cnt;
    logic [DIV_BIT-1:0] div_cnt_nxt;

    logic cmd_tick;
    logic start;
    logic stop;
    logic bit_last;
    logic idx_last;

    logic serial;
    logic bit_tick;
    logic done_tick;

    // Channel field and reserved bit carry no meaning on a single output.
    logic unused_cmd;
    assign unused_cmd = ^bus.i_data[7:3];

    assign cmd_tick = bus.i_rx_done_tick && (byte_cnt == CMD_POS);
    assign stop     = cmd_tick && bus.i_data[1];
    assign start    = cmd_tick && bus.i_data[0] && !bus.i_data[1];

    assign bit_last = (div_cnt == (shadow_speed[bit_idx] ? HIGH_LAST : LOW_LAST));
    assign idx_last = (bit_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt  <= '0;
            data_buf  <= '0;
            speed_buf <= '0;
        end else if (bus.i_rx_done_tick) begin
            for (int k = 0; k < NB; k++) begin
                if (byte_cnt == CNT_W'(k))
                    data_buf[8*k +: 8] <= bus.i_data;
                if (byte_cnt == CNT_W'(k + NB))
                    speed_buf[8*k +: 8] <= bus.i_data;
            end
            byte_cnt <= (byte_cnt == CMD_POS) ? '0 : byte_cnt + 1'b1;
        end
    end

    // The running pattern only changes on START, so later bytes are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_data  <= '0;
            shadow_speed <= '0;
            repeat_mode  <= 1'b0;
        end else if (start) begin
            shadow_data  <= data_buf;
            shadow_speed <= speed_buf;
            repeat_mode  <= bus.i_data[2];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            div_cnt <= '0;
        end else begin
            state   <= state_nxt;
            bit_idx <= bit_idx_nxt;
            div_cnt <= div_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        bit_idx_nxt = bit_idx;
        div_cnt_nxt = div_cnt;
        serial      = 1'b0;
        bit_tick    = 1'b0;
        done_tick   = 1'b0;

        if (state == RUN) begin
            serial    = shadow_data[bit_idx];
            bit_tick  = bit_last;
            done_tick = bit_last && idx_last;
        end

        if (stop) begin
            state_nxt   = IDLE;
            bit_idx_nxt = '0;
            div_cnt_nxt = '0;
            done_tick   = 1'b0;
        end else if (start) begin
            state_nxt   = RUN;
            bit_idx_nxt = '0;
            div_cnt_nxt = '0;
        end else if (state == RUN) begin
            if (bit_last) begin
                div_cnt_nxt = '0;
                if (idx_last) begin
                    bit_idx_nxt = '0;
                    state_nxt   = repeat_mode ? RUN : IDLE;
                end else begin
                    bit_idx_nxt = bit_idx + 1'b1;
                end
            end else begin
                div_cnt_nxt = div_cnt + 1'b1;
            end
        end
    end

    assign bus.o_serial_out = serial;
    assign bus.o_bit_tick   = bit_tick;
    assign bus.o_done_tick  = done_tick;

endmodule

// File: tb/tb_diff_freq_serial_out.sv
// Directed bench: packets are sent byte by byte and the serial output,
// bit ticks and done ticks are compared cycle by cycle against hand values.
module tb_diff_freq_serial_out;

    logic clk;
    logic rst;
    int   total;
    int   passed;

    diff_freq_serial_out_if bus();

    diff_freq_serial_out dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            passed++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_data         = b;
        bus.i_rx_done_tick = 1'b1;
        @(negedge clk);
        bus.i_rx_done_tick = 1'b0;
        bus.i_data         = 8'h00;
    endtask

    task automatic send_packet(input logic [31:0] d, input logic [31:0] s,
                               input logic [7:0] cmd);
        for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
        for (int k = 0; k < 4; k++) send_byte(s[8*k +: 8]);
        send_byte(cmd);
    endtask

    // Entered at the sampling point of the first bit's first clock.
    task automatic check_pass(input string tag, input logic [31:0] d,
                              input logic [31:0] s, input int exp_len);
        int nt;
        int nd;
        int cyc;
        int per;
        nt  = 0;
        nd  = 0;
        cyc = 0;
        for (int i = 0; i < 32; i++) begin
            per = s[i] ? 10 : 20;
            for (int c = 0; c < per; c++) begin
                check($sformatf("%s out b%0d c%0d", tag, i, c),
                      {31'd0, bus.o_serial_out}, {31'd0, d[i]});
                check($sformatf("%s tick b%0d c%0d", tag, i, c),
                      {30'd0, bus.o_bit_tick, bus.o_done_tick},
                      {30'd0, c == per - 1, (c == per - 1) && (i == 31)});
                nt += int'(bus.o_bit_tick);
                nd += int'(bus.o_done_tick);
                cyc++;
                @(negedge clk);
            end
        end
        check({tag, " bit_ticks"}, nt, 32);
        check({tag, " done_ticks"}, nd, 1);
        check({tag, " pass_len"}, cyc, exp_len);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s idle c%0d", tag, c),
                  {29'd0, bus.o_serial_out, bus.o_bit_tick, bus.o_done_tick},
                  32'd0);
            @(negedge clk);
        end
    endtask

    initial begin
        total              = 0;
        passed             = 0;
        rst                = 1'b1;
        bus.i_data         = 8'h00;
        bus.i_rx_done_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // reset state, then quiet without strobes
        idle_check("reset", 30);

        // one-shot pattern
        send_packet(32'h55FF00FF, 32'hFF00FF00, 8'h01);
        check_pass("oneshot", 32'h55FF00FF, 32'hFF00FF00, 480);
        idle_check("after_oneshot", 40);

        // repeat mode: two passes back to back
        send_packet(32'h55FF00FF, 32'hFF00FF00, 8'h05);
        check_pass("rep1", 32'h55FF00FF, 32'hFF00FF00, 480);
        check_pass("rep2", 32'h55FF00FF, 32'hFF00FF00, 480);
        // a no-command packet mid-pass must not disturb the running pattern
        send_packet(32'h12345678, 32'h00000000, 8'h00);
        repeat (480 - 18) @(negedge clk);
        check_pass("rep4", 32'h55FF00FF, 32'hFF00FF00, 480);
        send_packet(32'h55FF00FF, 32'hFF00FF00, 8'h02);
        idle_check("after_stop", 60);

        // START together with STOP stays idle
        send_packet(32'h55FF00FF, 32'hFF00FF00, 8'h03);
        idle_check("start_stop", 60);

        // reset mid-pattern, with a partial packet left in the byte counter
        send_packet(32'h55FF00FF, 32'hFF00FF00, 8'h01);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        repeat (43) @(negedge clk);
        check("pre_reset out", {31'd0, bus.o_serial_out}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("post_reset out", {31'd0, bus.o_serial_out}, 32'd0);
        idle_check("post_reset", 500);

        // fresh packet after reset: all-fast alternating pattern
        send_packet(32'hAAAAAAAA, 32'hFFFFFFFF, 8'h01);
        check_pass("fast", 32'hAAAAAAAA, 32'hFFFFFFFF, 320);
        idle_check("after_fast", 40);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
